// File: rtl/cap_sched.sv
// Round-robin capture scheduler: grants one of four requesters, samples din once per grant, queues {src,bit}.
// Latency: eligible req seen in IDLE -> gnt next cycle -> entry visible in FIFO the cycle after the grant.
// Backpressure: none toward requesters; a capture into a full FIFO is dropped and flags sticky overflow.
module cap_sched #(
  parameter int N_REQ = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic [1:0]       mode,
  input  logic             din,
  input  logic             pop,
  output logic [N_REQ-1:0] gnt,
  output logic             o_valid,
  output logic             o_data,
  output logic [1:0]       o_src,
  output logic             full,
  output logic             overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    GRANT     = 2'd1,
    WAIT_DROP = 2'd2
  } state_t;

  state_t             state_q;
  logic [1:0]         rr_q;
  logic [1:0]         win_q;
  logic [N_REQ-1:0]   gnt_q;

  logic [N_REQ-1:0]   elig;
  logic               pick_vld;
  logic [1:0]         pick_idx;
  logic [1:0]         cand;

  logic [2:0]         mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q;
  logic [AW-1:0]      rd_ptr_q;
  logic [CW-1:0]      count_q;
  logic [CW-1:0]      count_d;
  logic               valid_q;
  logic               full_q;
  logic               ovf_q;

  logic               push;
  logic               pop_ok;
  logic               push_ok;
  logic               drop;

  // Eligibility mask from mode: 0x = everyone, 11 = odd requesters only, 10 = paused
  always_comb begin
    elig = '0;
    case (mode)
      2'b00, 2'b01: elig = '1;
      2'b11:        elig = 4'b1010;
      default:      elig = '0;
    endcase
  end

  // Round-robin search: first eligible requester at or after rr_q, wrapping mod 4
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = rr_q;
    cand     = rr_q;
    for (int i = 0; i < N_REQ; i++) begin
      cand = rr_q + i[1:0];
      if (!pick_vld && req[cand] && elig[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  // Scheduler FSM; gnt is registered here and only held for the single GRANT cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rr_q    <= 2'd0;
      win_q   <= 2'd0;
      gnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_vld) begin
            win_q   <= pick_idx;
            gnt_q   <= N_REQ'(1) << pick_idx;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          gnt_q   <= '0;
          rr_q    <= win_q + 2'd1;
          state_q <= WAIT_DROP;
        end
        WAIT_DROP: begin
          // Winner must release its level before it can be considered again
          if (!req[win_q]) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Capture happens at the edge that ends GRANT; a same-cycle pop on a full FIFO makes room
  always_comb begin
    push    = (state_q == GRANT);
    pop_ok  = pop && valid_q;
    push_ok = push && (!full_q || pop_ok);
    drop    = push && !push_ok;
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Circular buffer storage, pointers, registered status flags and sticky overflow
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 3'd0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= {win_q, din};
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop_ok) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      valid_q <= (count_d != '0);
      full_q  <= (count_d == FULL_CNT);
      if (drop) ovf_q <= 1'b1;
    end
  end

  assign gnt      = gnt_q;
  assign o_valid  = valid_q;
  assign full     = full_q;
  assign overflow = ovf_q;
  assign o_src    = mem_q[rd_ptr_q][2:1];
  assign o_data   = mem_q[rd_ptr_q][0];

endmodule

// File: tb/tb_cap_sched.sv
// Self-checking bench for cap_sched: directed grant sequences, scoreboard of expected FIFO entries.
// Inputs change 1 time unit after posedge; outputs are sampled at the same point.
// Scoreboard entries are pushed when a capture is predicted and popped as the consumer drains.
module tb_cap_sched;
  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic [1:0] mode;
  logic       din;
  logic       pop;
  logic [3:0] gnt;
  logic       o_valid;
  logic       o_data;
  logic [1:0] o_src;
  logic       full;
  logic       overflow;

  int total;
  int bad;
  logic [2:0] sb[$];
  logic       exp_ovf;
  logic [3:0] seen;
  logic [2:0] tmp;

  cap_sched #(.N_REQ(4), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .req(req), .mode(mode), .din(din), .pop(pop),
    .gnt(gnt), .o_valid(o_valid), .o_data(o_data), .o_src(o_src),
    .full(full), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_head();
    chk("head_vld", 32'(o_valid), 32'd1);
    chk("head_ent", 32'({o_src, o_data}), 32'(sb[0]));
  endtask

  task automatic wait_gnt();
    int n;
    n = 0;
    while (gnt == 4'd0 && n < 16) begin
      cyc();
      n++;
    end
    chk("gnt_seen", 32'(|gnt), 32'd1);
  endtask

  // Called during the GRANT cycle: requester drops its line, din is presented, optional pop
  task automatic grant_step(input int s, input logic d, input logic p);
    chk("gnt_onehot", 32'(gnt), 32'd1 << s);
    din    = d;
    req[s] = 1'b0;
    if (p) begin
      chk_head();
      pop = 1'b1;
      tmp = sb.pop_front();
    end
    if (sb.size() < 4) sb.push_back({2'(s), d});
    else exp_ovf = 1'b1;
    cyc();
    pop = 1'b0;
    chk("gnt_drop", 32'(gnt), 32'd0);
  endtask

  task automatic one_req(input int s, input logic d, input logic p);
    req[s] = 1'b1;
    wait_gnt();
    grant_step(s, d, p);
    cyc();
  endtask

  task automatic drain();
    while (sb.size() > 0) begin
      chk_head();
      pop = 1'b1;
      cyc();
      pop = 1'b0;
      tmp = sb.pop_front();
    end
    chk("drain_empty", 32'(o_valid), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    sb.delete();
    exp_ovf = 1'b0;
  endtask

  initial begin
    clk = 1'b0; reset = 1'b1; req = 4'd0; mode = 2'b00; din = 1'b0; pop = 1'b0;
    total = 0; bad = 0; exp_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_vld", 32'(o_valid), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_src", 32'(o_src), 32'd0);
    chk("rst_data", 32'(o_data), 32'd0);
    reset = 1'b0;

    // Single request held past its grant: exactly one capture
    req = 4'b0001; din = 1'b1;
    cyc();
    chk("t1_gnt", 32'(gnt), 32'd1);
    sb.push_back({2'd0, 1'b1});
    cyc();
    chk("t1_gnt_off", 32'(gnt), 32'd0);
    chk_head();
    seen = 4'd0;
    repeat (5) begin cyc(); seen |= gnt; end
    chk("t1_hold_nognt", 32'(seen), 32'd0);
    req = 4'd0;
    cyc();
    drain();

    // All requesting: round-robin 0,1,2,3 then wrap back to 0
    do_reset();
    req = 4'b1111;
    for (int s = 0; s < 4; s++) begin
      wait_gnt();
      grant_step(s, s[0], 1'b0);
      if (s < 3) begin
        cyc();
        req[s] = 1'b1;
      end
    end
    req = 4'd0;
    cyc();
    drain();
    req = 4'b1111;
    wait_gnt();
    grant_step(0, 1'b1, 1'b0);
    req = 4'd0;
    cyc();
    drain();

    // Odd-only mode, then paused mode
    mode = 2'b11; req = 4'b0101;
    seen = 4'd0;
    repeat (6) begin cyc(); seen |= gnt; end
    chk("t3_even_blocked", 32'(seen), 32'd0);
    req = 4'b1010;
    wait_gnt();
    grant_step(1, 1'b0, 1'b0);
    wait_gnt();
    grant_step(3, 1'b1, 1'b0);
    cyc();
    drain();
    mode = 2'b10; req = 4'b1111;
    seen = 4'd0;
    repeat (20) begin cyc(); seen |= gnt; end
    chk("t3_paused", 32'(seen), 32'd0);
    req = 4'd0; mode = 2'b00;
    cyc();

    // Fill, overflow on a 5th capture, then simultaneous pop+capture on full
    one_req(0, 1'b1, 1'b0);
    one_req(1, 1'b0, 1'b0);
    one_req(2, 1'b1, 1'b0);
    one_req(3, 1'b1, 1'b0);
    chk("t4_full", 32'(full), 32'd1);
    chk("t4_no_ovf", 32'(overflow), 32'(exp_ovf));
    one_req(0, 1'b0, 1'b0);
    chk("t4_ovf", 32'(overflow), 32'(exp_ovf));
    chk("t4_full2", 32'(full), 32'd1);
    chk_head();
    one_req(2, 1'b0, 1'b1);
    chk("t4_full_after_pp", 32'(full), 32'd1);
    chk("t4_ovf_sticky", 32'(overflow), 32'(exp_ovf));
    drain();
    chk("t4_not_full", 32'(full), 32'd0);

    // Reset during GRANT with two entries queued and rr away from 0
    one_req(3, 1'b0, 1'b0);
    one_req(1, 1'b1, 1'b0);
    req = 4'b0100;
    wait_gnt();
    chk("t5_pre_gnt", 32'(gnt), 32'h4);
    reset = 1'b1;
    #1;
    chk("t5_rst_gnt", 32'(gnt), 32'd0);
    chk("t5_rst_vld", 32'(o_valid), 32'd0);
    chk("t5_rst_ovf", 32'(overflow), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    sb.delete();
    exp_ovf = 1'b0;
    req = 4'b1111;
    wait_gnt();
    grant_step(0, 1'b1, 1'b0);
    req = 4'd0;
    cyc();
    drain();

    // Mode change to paused during GRANT still completes the capture
    req = 4'b0100;
    wait_gnt();
    mode = 2'b10;
    grant_step(2, 1'b1, 1'b0);
    cyc();
    drain();
    mode = 2'b00;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
